xgriscv_wb_stage: RTL
=====================

# xgriscv_wb_stage

Writeback stage of the xgriscv pipeline: MEM/WB pipeline register, load-data alignment and sign extension, and result selection. Drives the register file's write port (`we3`/`wa3`/`wd3`) and publishes the same result as a bypass source for the execute stage. Sits directly between the data-memory stage and the register file.

## Interface
Parameters:
- `XLEN`, 32, datapath width (equals `` `XLEN ``)
- `RFIDX_WIDTH`, 5, register index width (equals `` `RFIDX_WIDTH ``)

Ports:
- `clk`  in  1  core clock, all state on rising edge
- `rstn`  in  1  synchronous reset, active low
- `m_valid`  in  1  MEM stage presents an instruction
- `m_regwrite`  in  1  instruction writes rd
- `m_rd`  in  RFIDX_WIDTH  destination register
- `m_wbsel`  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate
- `m_lsfunct3`  in  3  load type (funct3)
- `m_alures`  in  XLEN  ALU result / effective address
- `m_memdata`  in  XLEN  raw aligned word from data memory
- `m_pcplus4`, `m_imm`  in  XLEN each  PC+4, U-immediate
- `wb_stall`  in  1  hold WB register
- `wb_flush`  in  1  kill WB contents
- `we3`  out  1  regfile write enable
- `wa3`  out  RFIDX_WIDTH  regfile write address
- `wd3`  out  XLEN  regfile write data
- `fwd_valid`, `fwd_rd`, `fwd_data`  out  1/RFIDX_WIDTH/XLEN  bypass source
- `wb_misalign`  out  1  pulse: misaligned load suppressed
- `instret`  out  64  retired-instruction count (macro-gated)

## Operation
- WB register captures all `m_*` fields on rising edge when `wb_stall`=0; `valid_q` ← `m_valid`.
- `fresh_q` set on every capture, cleared on any cycle with `wb_stall`=1 (held instruction writes/retires once only).
- Load extraction from `m_memdata` by `alures_q[1:0]`: 000 lb byte sign-extended; 100 lbu zero-extended; 001 lh / 101 lhu halfword at offset 0 or 2; 010 lw whole word; 011/110/111 treated as lw.
- Misaligned: lh/lhu with addr[0]=1, lw with addr[1:0]≠0, only when wbsel=01.
- `wd3`: mux of alures/extracted load/pcplus4/imm per `wbsel_q`.
- `we3` = `valid_q & fresh_q & regwrite_q & (rd_q≠0) & ~misalign`; `wa3`=`rd_q`.
- `fwd_valid` = `valid_q & regwrite_q & (rd_q≠0) & ~misalign` (not gated by `fresh_q`: held value stays forwardable); `fwd_rd`/`fwd_data` = `wa3`/`wd3`.
- `wb_misalign` = `valid_q & fresh_q & misalign`.

## Timing
- Latency: one cycle from `m_*` to `we3`/`wd3`; regfile commits on the following falling edge, so decode reads the value in the second half of the same cycle.
- Outputs combinational from WB register only; no input-to-output combinational path.
- Reset (`rstn`=0 at rising edge): `valid_q`=0, `fresh_q`=0, all data fields 0, `instret`=0 → `we3`=0, `wa3`=0, `wd3`=0, `fwd_valid`=0, `wb_misalign`=0. Reset mid-write: pending write dropped.
- `wb_flush` and `wb_stall` same cycle: flush wins, `valid_q`←0.
- `wb_flush` alone: `valid_q`←0; incoming `m_*` discarded.
- rd=x0: no write, no forward, still retires.
- Misaligned load: no write, retires not counted.

## Configuration
- `XGRISCV_INSTRET_EN` defined: 64-bit `instret` increments by 1 on each cycle with `valid_q & fresh_q & ~misalign`; wraps from 2^64−1 to 0; reset to 0.
- Undefined: counter not built, `instret` tied to 0.

## Test plan
- Reset: hold `rstn`=0 two cycles with `m_valid`=1 → `we3`=0, `wd3`=0, `instret`=0.
- ALU op rd=5, alures=0x1234_5678, wbsel=00 → next cycle `we3`=1, `wa3`=5, `wd3`=0x12345678; `instret`=1 after.
- Loads, memdata=0x80FF_7F01: lb addr 0x..3 → 0xFFFFFF80; lbu addr 0x..1 → 0x0000007F; lh addr 0x..2 → 0xFFFF80FF; lhu addr 0x..0 → 0x00007F01; lw addr 0x..1 → `we3`=0, `wb_misalign`=1 one cycle.
- Stall 3 cycles on rd=7 write → `we3`=1 first cycle only, `fwd_valid`=1 all 4 cycles, `instret` +1.
- Flush+stall same cycle with valid rd=3 entering → `valid_q`=0, no write; rd=0 ALU op → `we3`=0, `fwd_valid`=0, `instret` +1.
- With `XGRISCV_INSTRET_EN`, force counter 0xFFFF_FFFF_FFFF_FFFF, retire one → 0.

Source files
------------

// File: rtl/xgriscv_wb_stage.sv
// Writeback stage: MEM/WB register, load alignment/extension, result select, bypass.
// Optional retired-instruction counter built when XGRISCV_INSTRET_EN is defined.
module xgriscv_wb_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   m_valid,
  input  logic                   m_regwrite,
  input  logic [RFIDX_WIDTH-1:0] m_rd,
  input  logic [1:0]             m_wbsel,
  input  logic [2:0]             m_lsfunct3,
  input  logic [XLEN-1:0]        m_alures,
  input  logic [XLEN-1:0]        m_memdata,
  input  logic [XLEN-1:0]        m_pcplus4,
  input  logic [XLEN-1:0]        m_imm,
  input  logic                   wb_stall,
  input  logic                   wb_flush,
  output logic                   we3,
  output logic [RFIDX_WIDTH-1:0] wa3,
  output logic [XLEN-1:0]        wd3,
  output logic                   fwd_valid,
  output logic [RFIDX_WIDTH-1:0] fwd_rd,
  output logic [XLEN-1:0]        fwd_data,
  output logic                   wb_misalign,
  output logic [63:0]            instret
);

  logic                   valid_q, valid_d;
  logic                   fresh_q, fresh_d;
  logic                   regwrite_q, regwrite_d;
  logic [RFIDX_WIDTH-1:0] rd_q, rd_d;
  logic [1:0]             wbsel_q, wbsel_d;
  logic [2:0]             lsfunct3_q, lsfunct3_d;
  logic [XLEN-1:0]        alures_q, alures_d;
  logic [XLEN-1:0]        memdata_q, memdata_d;
  logic [XLEN-1:0]        pcplus4_q, pcplus4_d;
  logic [XLEN-1:0]        imm_q, imm_d;

  // Capture on unstalled cycles; flush overrides stall and drops the incoming op.
  always_comb begin
    valid_d    = valid_q;
    fresh_d    = fresh_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    wbsel_d    = wbsel_q;
    lsfunct3_d = lsfunct3_q;
    alures_d   = alures_q;
    memdata_d  = memdata_q;
    pcplus4_d  = pcplus4_q;
    imm_d      = imm_q;
    if (wb_flush) begin
      valid_d = 1'b0;
      fresh_d = 1'b0;
    end else if (wb_stall) begin
      fresh_d = 1'b0;
    end else begin
      valid_d    = m_valid;
      fresh_d    = 1'b1;
      regwrite_d = m_regwrite;
      rd_d       = m_rd;
      wbsel_d    = m_wbsel;
      lsfunct3_d = m_lsfunct3;
      alures_d   = m_alures;
      memdata_d  = m_memdata;
      pcplus4_d  = m_pcplus4;
      imm_d      = m_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q    <= 1'b0;
      fresh_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wbsel_q    <= 2'b00;
      lsfunct3_q <= 3'b000;
      alures_q   <= '0;
      memdata_q  <= '0;
      pcplus4_q  <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      fresh_q    <= fresh_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wbsel_q    <= wbsel_d;
      lsfunct3_q <= lsfunct3_d;
      alures_q   <= alures_d;
      memdata_q  <= memdata_d;
      pcplus4_q  <= pcplus4_d;
      imm_q      <= imm_d;
    end
  end

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;
  logic            misalign;
  logic            rd_nz;

  // Load lane extraction; unknown funct3 codes behave as lw.
  always_comb begin
    ld_byte   = 8'h00;
    ld_half   = alures_q[1] ? memdata_q[31:16] : memdata_q[15:0];
    load_data = memdata_q;
    misalign  = 1'b0;
    case (alures_q[1:0])
      2'd0:    ld_byte = memdata_q[7:0];
      2'd1:    ld_byte = memdata_q[15:8];
      2'd2:    ld_byte = memdata_q[23:16];
      default: ld_byte = memdata_q[31:24];
    endcase
    case (lsfunct3_q)
      3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = memdata_q;
    endcase
    if (wbsel_q == 2'b01) begin
      case (lsfunct3_q)
        3'b000, 3'b100: misalign = 1'b0;
        3'b001, 3'b101: misalign = alures_q[0];
        default:        misalign = (alures_q[1:0] != 2'b00);
      endcase
    end
  end

  always_comb begin
    case (wbsel_q)
      2'b00:   wd3 = alures_q;
      2'b01:   wd3 = load_data;
      2'b10:   wd3 = pcplus4_q;
      default: wd3 = imm_q;
    endcase
  end

  assign rd_nz       = (rd_q != '0);
  assign wa3         = rd_q;
  assign we3         = valid_q & fresh_q & regwrite_q & rd_nz & ~misalign;
  // A held (stalled) result remains a valid bypass source.
  assign fwd_valid   = valid_q & regwrite_q & rd_nz & ~misalign;
  assign fwd_rd      = wa3;
  assign fwd_data    = wd3;
  assign wb_misalign = valid_q & fresh_q & misalign;

`ifdef XGRISCV_INSTRET_EN
  logic [63:0] instret_q, instret_d;
  logic        retire;

  assign retire = valid_q & fresh_q & ~misalign;

  always_comb begin
    instret_d = instret_q + 64'(retire);
  end

  always_ff @(posedge clk) begin
    if (!rstn) instret_q <= 64'd0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule
